n_bit_divider: RTL and testbench

N_BIT_DIVIDER -- requirements
Module: n_bit_divider

---
 rtl/n_bit_divider_if.sv | 39 +++
 rtl/n_bit_divider.sv | 169 ++++++++++++++++
 tb/tb_n_bit_divider.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/n_bit_divider_if.sv
// ---------------------------------------------------------------------------
// n_bit_divider_if
// Handshake and data bundle for n_bit_divider.
//   in_valid / in_ready    : operand handshake (dividend, divisor)
//   out_valid / out_ready  : result handshake (quotient, remainder)
//   div_by_zero            : only when DIV_BY_ZERO_FLAG_EN is defined
// Modports: master = operand producer / result consumer, slave = divider.
// ---------------------------------------------------------------------------
interface n_bit_divider_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic         div_by_zero;
`endif

  modport master (
    output in_valid, dividend, divisor, out_ready,
`ifdef DIV_BY_ZERO_FLAG_EN
    input  div_by_zero,
`endif
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
`ifdef DIV_BY_ZERO_FLAG_EN
    output div_by_zero,
`endif
    output in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/n_bit_divider.sv
// ---------------------------------------------------------------------------
// n_bit_divider
// Unsigned N-bit restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : n_bit_divider_if.slave (operand/result handshakes)
// Timing: operands latched on the accepting edge, N iteration edges, then
// one more edge into DONE, so out_valid is first high N+1 edges after accept.
// Result is held in DONE until out_ready is seen.
// Optional: DIV_BY_ZERO_FLAG_EN adds div_by_zero and finishes a zero-divisor
// operation one edge after accept.
// ---------------------------------------------------------------------------
module n_bit_divider #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  n_bit_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  pr_q, pr_d;     // partial remainder
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic          dbz_q, dbz_d;
`endif

  logic [N:0]    pr_shift;
  logic [N:0]    trial;

  // The working remainder is N+1 bits only during the trial subtraction; a
  // kept value is always below the divisor (or a dividend prefix when the
  // divisor is zero), so N stored bits suffice.
  always_comb begin
    pr_shift = {pr_q, dvd_q[N-1]};
    trial    = pr_shift - {1'b0, dvs_q};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    dbz_d       = dbz_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d      = bus.dividend;
          dvs_d      = bus.divisor;
          pr_d       = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end

      BUSY: begin
`ifdef DIV_BY_ZERO_FLAG_EN
        // Zero divisor short-circuits straight to the result on the first
        // BUSY edge; the normal iteration below is the else branch.
        if (dvs_q == '0) begin
          quo_d       = '1;
          rem_d       = dvd_q;
          dbz_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else
`endif
        if (cnt_q == CW'(N)) begin
          quo_d       = dvd_q;
          rem_d       = pr_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef DIV_BY_ZERO_FLAG_EN
          dbz_d       = 1'b0;
`endif
        end else begin
          if (!trial[N]) begin
            pr_d  = trial[N-1:0];
            dvd_d = {dvd_q[N-2:0], 1'b1};
          end else begin
            pr_d  = pr_shift[N-1:0];
            dvd_d = {dvd_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
`ifdef DIV_BY_ZERO_FLAG_EN
          dbz_d       = 1'b0;
`endif
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef DIV_BY_ZERO_FLAG_EN
  assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_n_bit_divider.sv
// ---------------------------------------------------------------------------
// tb_n_bit_divider
// Directed scenarios on an N=8 divider, then randomized traffic with random
// result stalls on an N=16 divider checked against plain integer division.
// Honours DIV_BY_ZERO_FLAG_EN when defined at compile time.
// ---------------------------------------------------------------------------
module tb_n_bit_divider;

  localparam int NTX = 2500;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  n_bit_divider_if #(.N(8))  if8 ();
  n_bit_divider_if #(.N(16)) if16 ();

  n_bit_divider #(.N(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
  n_bit_divider #(.N(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: integer division; a zero divisor gives all-ones / dividend.
  function automatic logic [31:0] ref_div16(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return {16'hFFFF, a};
    return {a / b, a % b};
  endfunction

  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 40 && !if8.in_ready; i++) begin
      @(posedge clk); #1;
    end
    if8.dividend = a;
    if8.divisor  = b;
    if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge until out_valid is seen; 0 = none.
  task automatic wait_result8(input bit scramble, output int lat);
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (scramble) begin
        if8.dividend = 8'($urandom);
        if8.divisor  = 8'($urandom);
        if8.in_valid = 1'($urandom_range(1));
      end
      if (if8.out_valid) begin
        lat = e;
        break;
      end
    end
    if8.in_valid = 1'b0;
  endtask

  // ---------------- N=16 scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_res16 = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (if16.in_valid && if16.in_ready)
        exp_q.push_back(ref_div16(if16.dividend, if16.divisor));
      if (if16.out_valid && if16.out_ready) begin
        n_res16++;
        if (exp_q.size() == 0) begin
          check("r16_spurious", 64'd1, 64'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("r16_quotient", 64'(if16.quotient), 64'(e[31:16]));
          check("r16_remainder", 64'(if16.remainder), 64'(e[15:0]));
        end
      end
    end
  end

  initial begin
    int lat;
    int sent;
    int cyc;
    bit acc;
    logic [15:0] a16, b16;

    if8.in_valid = 1'b0;  if8.dividend = '0;  if8.divisor = '0;  if8.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.dividend = '0; if16.divisor = '0; if16.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(if8.out_valid), 64'd0);
    check("rst_quotient", 64'(if8.quotient), 64'd0);
    check("rst_remainder", 64'(if8.remainder), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(if8.in_ready), 64'd1);

    // 200/7
    accept8(8'd200, 8'd7);
    check("a_in_ready_busy", 64'(if8.in_ready), 64'd0);
    wait_result8(1'b0, lat);
    check("a_latency", 64'(lat), 64'd9);
    check("a_quotient", 64'(if8.quotient), 64'd28);
    check("a_remainder", 64'(if8.remainder), 64'd4);
    @(posedge clk); #1;
    check("a_in_ready_back", 64'(if8.in_ready), 64'd1);
    check("a_out_valid_off", 64'(if8.out_valid), 64'd0);

    // 255/1 held under back-pressure with ignored in_valid pulses
    if8.out_ready = 1'b0;
    accept8(8'd255, 8'd1);
    wait_result8(1'b0, lat);
    check("b_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 20; i++) begin
      if8.in_valid = 1'($urandom_range(1));
      if8.dividend = 8'($urandom);
      if8.divisor  = 8'($urandom);
      @(posedge clk); #1;
      check("b_hold_valid", 64'(if8.out_valid), 64'd1);
      check("b_hold_quotient", 64'(if8.quotient), 64'd255);
      check("b_hold_remainder", 64'(if8.remainder), 64'd0);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("b_release_valid", 64'(if8.out_valid), 64'd0);
    check("b_release_ready", 64'(if8.in_ready), 64'd1);

    // 5/0
    accept8(8'd5, 8'd0);
    wait_result8(1'b0, lat);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("z_latency", 64'(lat), 64'd1);
    check("z_flag", 64'(if8.div_by_zero), 64'd1);
`else
    check("z_latency", 64'(lat), 64'd9);
`endif
    check("z_quotient", 64'(if8.quotient), 64'd255);
    check("z_remainder", 64'(if8.remainder), 64'd5);

    // Boundaries: divisor > dividend, zero dividend
    accept8(8'd7, 8'd200);
    wait_result8(1'b0, lat);
    check("g_latency", 64'(lat), 64'd9);
    check("g_quotient", 64'(if8.quotient), 64'd0);
    check("g_remainder", 64'(if8.remainder), 64'd7);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("g_flag", 64'(if8.div_by_zero), 64'd0);
`endif
    accept8(8'd0, 8'd5);
    wait_result8(1'b0, lat);
    check("d0_quotient", 64'(if8.quotient), 64'd0);
    check("d0_remainder", 64'(if8.remainder), 64'd0);

    // Reset abort mid-operation
    accept8(8'd100, 8'd13);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(if8.out_valid), 64'd0);
    check("abort_quotient", 64'(if8.quotient), 64'd0);
    check("abort_remainder", 64'(if8.remainder), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 64'(if8.out_valid), 64'd0);
    end
    check("abort_in_ready", 64'(if8.in_ready), 64'd1);
    accept8(8'd9, 8'd3);
    wait_result8(1'b0, lat);
    check("abort_next_latency", 64'(lat), 64'd9);
    check("abort_next_quotient", 64'(if8.quotient), 64'd3);
    check("abort_next_remainder", 64'(if8.remainder), 64'd0);

    // Operands change every cycle while busy
    accept8(8'd3, 8'd10);
    wait_result8(1'b1, lat);
    check("s_latency", 64'(lat), 64'd9);
    check("s_quotient", 64'(if8.quotient), 64'd0);
    check("s_remainder", 64'(if8.remainder), 64'd3);
    @(posedge clk); #1;

    // Randomized N=16 traffic with result stalls
    sent = 0;
    cyc  = 0;
    while (sent < NTX && cyc < 80000) begin
      @(negedge clk);
      acc = if16.in_valid && if16.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if16.out_ready = ($urandom_range(3) != 0);
      if ((!if16.in_valid || acc) && sent < NTX) begin
        if ($urandom_range(3) != 0) begin
          a16 = 16'($urandom);
          b16 = 16'($urandom);
          case ($urandom_range(7))
            0: b16 = '0;
            1: b16 = 16'($urandom_range(1, 15));
            2: begin a16 = 16'($urandom_range(0, 255)); b16 = 16'($urandom_range(256, 65535)); end
            3: a16 = '0;
            4: b16 = 16'd1;
            default: ;
          endcase
          if16.dividend = a16;
          if16.divisor  = b16;
          if16.in_valid = 1'b1;
        end else begin
          if16.in_valid = 1'b0;
        end
      end else if (sent >= NTX) begin
        if16.in_valid = 1'b0;
      end
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || if16.out_valid); i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("r16_accepts", 64'(sent), 64'(NTX));
    check("r16_pending", 64'(exp_q.size()), 64'd0);
    check("r16_result_count", 64'(n_res16), 64'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
